board_input_conditioner: RTL
============================

Name: board_input_conditioner

Overview:
- Input-side counterpart of the DE10-Lite HEX display path: conditions raw board inputs (KEY[1:0] push-buttons, SW[9:0] slide switches) before they reach the multicore CPU / board top logic.
- Per bit: 2-flop synchronizer, optional polarity inversion, counter-based debounce FSM, and one-cycle rise/fall strobes.
- Instantiated once in the board top, between the pins and any logic that consumes KEY/SW.

Parameters:
- WIDTH, 12, number of conditioned inputs; board wiring is {SW[9:0], KEY[1:0]}.
- INVERT_MASK, 12'h003, per-bit inversion applied before synchronization; 1 = active-low input such as KEY.
- DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a change (5 ms at 50 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  synchronous, active-high reset
- raw_in  input  WIDTH  asynchronous pin levels
- level  output  WIDTH  debounced, polarity-corrected level
- rise  output  WIDTH  one-cycle strobe when level goes 0->1 ("pressed")
- fall  output  WIDTH  one-cycle strobe when level goes 1->0 ("released")
- any_rise  output  1  OR-reduction of rise, registered together with rise

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync flops, level, rise, fall, any_rise all 0.
  - Counters 0; every FSM in STABLE_LO.
  - rst overrides all other activity, including a debounce in progress; no strobe is emitted in the reset cycle or the following one.
- Input stage: x = raw_in ^ INVERT_MASK → s1 → s2 (two flops, both reset to 0). The FSM sees only s2.
- Per-bit FSM; states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; counter width $clog2(DEBOUNCE_CYCLES+1).
  - STABLE_LO: s2=1 → WAIT_HI, cnt<=1; else hold, cnt<=0.
  - WAIT_HI:
    - s2=0 → STABLE_LO, cnt<=0 (glitch rejected, no strobe).
    - s2=1 and cnt==DEBOUNCE_CYCLES → STABLE_HI, level<=1, rise<=1, cnt<=0.
    - otherwise cnt<=cnt+1.
  - STABLE_HI / WAIT_LO: mirror images of the above, with fall instead of rise.
  - DEBOUNCE_CYCLES=1 is legal and still passes through WAIT_x, so the minimum acceptance time is 2 samples.
- Latency:
  - raw change set up before edge E0 appears in s2 after E1.
  - The level/strobe register updates at edge E1+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after E0, provided raw stays constant throughout.
- Strobes:
  - rise and fall are high for exactly one cycle per accepted transition and are never both high on the same bit.
  - any_rise is registered in the same cycle as rise.
- Bits are fully independent; simultaneous transitions on several bits strobe in the same cycle.
- A bit already high when rst deasserts (e.g. SW set) is treated as a normal 0->1 transition: rise fires after the standard latency.
- A pulse shorter than DEBOUNCE_CYCLES+1 samples causes no change at all.

Decomposition:
- board_io_pkg:
  - constants DE10_N_KEYS=2, DE10_N_SW=10, DE10_IN_WIDTH=12, DE10_KEY_INVERT=12'h003, DEBOUNCE_5MS_50MHZ=250000;
  - enum dbnc_state_t {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO}.
- Sub-module debounce_bit: synchronizer + FSM + counter for one bit, with ports clk, rst, din, level, rise, fall.
- Top: generate loop over WIDTH, plus inversion and any_rise.

Test Plan (WIDTH=12, INVERT_MASK=12'h003, DEBOUNCE_CYCLES=8 unless noted):
- Reset: hold rst 3 cycles with raw_in=12'h003 → level=0, rise=fall=any_rise=0 throughout and for 12 cycles after release.
- Clean KEY0 press: raw_in=12'h002 from edge E0 → level[0]=1 and rise[0]=1 (one cycle) at E0+10, any_rise=1 in the same cycle; release to 12'h003 → fall[0]=1 at 10 edges after the change.
- Bounce: toggle SW0 (bit 2) high 5 cycles, low 2, high 4, low → no rise and level[2]=0 throughout; then hold high 9+ cycles → a single rise[2].
- Switch set at reset: raw_in=12'h007 held through rst deassert → rise[2]=1 exactly once, 10 edges after deassert; level=12'h004 afterwards.
- Simultaneous: bits 0, 5 and 11 change on the same edge → rise strobes on the same cycle with rise=12'h821, any_rise=1 for one cycle.
- Reset mid-debounce: assert rst when a WAIT_HI counter is at 6 → no strobe, FSM returns to STABLE_LO; with DEBOUNCE_CYCLES=1 a 2-sample high is accepted and a 1-sample high is rejected.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants and types for the DE10-Lite board input path.
package board_io_pkg;

    localparam int DE10_N_KEYS        = 2;
    localparam int DE10_N_SW          = 10;
    localparam int DE10_IN_WIDTH      = 12;
    localparam logic [11:0] DE10_KEY_INVERT = 12'h003;
    localparam int DEBOUNCE_5MS_50MHZ = 250000;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } dbnc_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, counter-based debounce FSM,
// registered level and one-cycle rise/fall strobes.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic        s1;
    logic        s2;
    dbnc_state_t state;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Accept a change only after it has been seen on DEBOUNCE_CYCLES+1 consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s2) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions raw KEY/SW pins: polarity correction, per-bit synchronize and
// debounce, rise/fall strobes and a combined press indication.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int               WIDTH           = DE10_IN_WIDTH,
    parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(DE10_KEY_INVERT),
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_rise
);

    logic [WIDTH-1:0] x;

    assign x = raw_in ^ INVERT_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .din  (x[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // OR of the per-bit strobe flops: changes on the same edge as rise, no extra latency.
    assign any_rise = |rise;

endmodule
